part4_bist: RTL and testbench
=============================

# part4_bist

Self-test driver and response compactor for the `Part4` synthesis-optimisation block. It is the other end of that block's interface: it generates the 6-bit `inpBus` stimulus from an LFSR and collects the 5-bit `outBus` response into a 16-bit MISR signature. After a run it compares the signature against a golden value. It sits beside `Part4` in the same clock domain, so pre- and post-synthesis netlists can be checked for equivalence on silicon or in gate-level simulation.

## Interface
- `PAT_COUNT`, default 63: number of patterns applied per run (1..63).
- `SEED`, default 6'h01: LFSR start value, non-zero.
- `DUT_LAT`, default 1: cycles from `dut_in` to the matching `dut_out` (1..4).
- `GOLDEN`, default 16'h0000: expected final signature.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE and DONE only.
- `dut_in`  out  6  stimulus, drives `Part4.inpBus`.
- `dut_out`  in  5  response, from `Part4.outBus`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `signature == GOLDEN`, valid while `done`.
- `signature`  out  16  current MISR contents.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN after the PAT_COUNT-th pattern.
  - DRAIN -> DONE after DUT_LAT cycles.
  - DONE -> RUN on `start`.
- On entry to RUN, the LFSR loads SEED, and the MISR, pattern counter and valid pipe clear.
- LFSR (x^6+x^5+1, shift-left): next = {q[4:0], q[5]^q[4]}.
  - Advances every RUN cycle.
  - `dut_in` = LFSR value in RUN; 6'h00 in all other states.
- Valid pipe: DUT_LAT-deep shift register, fed 1 in RUN and 0 otherwise. Its output qualifies MISR capture.
- MISR update on a qualified cycle: sig_next = {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {11'b0, dut_out}. Otherwise it holds.
- Pattern counter is 6 bits. RUN ends when count == PAT_COUNT-1 at a clock edge. No wrap is possible within range.
- `start` in RUN/DRAIN is ignored. `start` held high in DONE restarts immediately.
- `pass` is registered on entry to DONE and held until the next run or reset.
- Reset (`reset`==0 at an edge), from any state including mid-run:
  - state IDLE;
  - `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0;
  - LFSR=SEED, counter and valid pipe cleared.

## Timing
- `start` high at edge N -> RUN from N+1. `dut_in`=SEED and `busy`=1 during cycle N+1.
- Patterns are driven in cycles N+1 .. N+PAT_COUNT.
- Captures happen at edges N+1+DUT_LAT .. N+PAT_COUNT+DUT_LAT.
- `done`=1 and `pass` valid from cycle N+PAT_COUNT+DUT_LAT+1. `busy` falls in the same cycle.
- Total run: PAT_COUNT+DUT_LAT cycles of `busy`.
- All outputs are registered. No combinational path from `start` or `dut_out` to any output.

## Structure
- Package `part4_bist_pkg`:
  - state enum;
  - LFSR width/taps, MISR width, MISR polynomial 16'h1021;
  - `Part4` bus widths (6 in, 5 out).
- Sub-module `misr16`: enable, data[4:0], clear, sig[15:0]. The LFSR, FSM and valid pipe stay in `part4_bist`.
- Instantiated next to `Part4` in a wrapper; `Part4` itself is unchanged.

## Test plan
- Reset, then idle 5 cycles -> `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `signature`=16'h0000.
- PAT_COUNT=5, SEED=6'h01, pulse `start` -> `dut_in` = 01, 02, 04, 08, 10 on consecutive cycles, then 00. `busy` high for 6 cycles (DUT_LAT=1).
- PAT_COUNT=2, DUT_LAT=1, `dut_out` tied 5'h1F -> `signature` 16'h001F after the first capture, then 16'h0021. With GOLDEN=16'h0021, `pass`=1 with `done`.
- Same run with GOLDEN=16'h0000 -> `done`=1, `pass`=0. A further `start` pulse during DRAIN has no effect.
- Pull `reset` low in the 3rd RUN cycle -> next cycle state IDLE, all outputs at reset values. A new `start` reruns from SEED with a clean MISR.
- Full 63-pattern run against `Part4` RTL, then against its synthesised netlist -> identical signatures and `pass`=1 with GOLDEN set from the RTL run.

Source files
------------

// File: rtl/part4_bist_pkg.sv
// part4_bist_pkg
//   Shared types and constants for the Part4 self-test driver: the run-control
//   state enum, LFSR/MISR geometry, the MISR feedback polynomial, the bus widths
//   of the Part4 block under test, and the LFSR step function.
package part4_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Part4 interface widths
    localparam int unsigned P4_IN_W  = 6;
    localparam int unsigned P4_OUT_W = 5;

    // Stimulus LFSR: x^6 + x^5 + 1, shift-left, feedback from bits 5 and 4
    localparam int unsigned          LFSR_W    = 6;
    localparam logic [LFSR_W-1:0]    LFSR_TAPS = 6'b11_0000;

    // Response compactor
    localparam int unsigned          MISR_W    = 16;
    localparam logic [MISR_W-1:0]    MISR_POLY = 16'h1021;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/part4_bist_misr.sv
// misr16
//   16-bit multiple-input signature register compacting the 5-bit Part4
//   response. Shift-left with polynomial 16'h1021 feedback from the MSB; the
//   response is XORed into the low bits.
//
//   clk       in   clock, rising edge
//   reset     in   synchronous active-low reset, clears the signature
//   enable    in   capture dut response this cycle
//   clear     in   zero the signature (wins over enable)
//   data      in   5-bit response word
//   sig       out  registered signature
//   sig_next  out  value sig takes at the coming edge (lets the owner register
//                  a compare result in the same cycle as the final capture)
module misr16
    import part4_bist_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [P4_OUT_W-1:0] data,
    output logic [MISR_W-1:0]   sig,
    output logic [MISR_W-1:0]   sig_next
);

    always_comb begin
        sig_next = sig;
        if (clear) begin
            sig_next = '0;
        end else if (enable) begin
            sig_next = {sig[MISR_W-2:0], 1'b0}
                     ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                     ^ {{(MISR_W-P4_OUT_W){1'b0}}, data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sig <= '0;
        end else begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/part4_bist.sv
// part4_bist
//   Self-test driver for Part4. Drives LFSR patterns onto Part4.inpBus for
//   PAT_COUNT cycles, waits DUT_LAT cycles for the last response, compacts
//   every response into a MISR and flags whether the final signature matches
//   GOLDEN.
//
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   start      in   run request (honoured in IDLE and DONE only)
//   dut_in     out  stimulus to Part4.inpBus (zero outside RUN)
//   dut_out    in   response from Part4.outBus
//   busy       out  run in progress (RUN or DRAIN)
//   done       out  run finished, pass valid
//   pass       out  final signature equals GOLDEN
//   signature  out  current MISR contents
module part4_bist
    import part4_bist_pkg::*;
#(
    parameter int unsigned       PAT_COUNT = 63,
    parameter logic [LFSR_W-1:0] SEED      = 6'h01,
    parameter int unsigned       DUT_LAT   = 1,
    parameter logic [MISR_W-1:0] GOLDEN    = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [P4_IN_W-1:0]  dut_in,
    input  logic [P4_OUT_W-1:0] dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [MISR_W-1:0]   signature
);

    localparam logic [5:0] PAT_LAST = 6'(PAT_COUNT - 1);
    localparam logic [5:0] LAT_LAST = 6'(DUT_LAT - 1);

    state_t              state, state_d;
    logic [LFSR_W-1:0]   lfsr, lfsr_d;
    logic [5:0]          cnt, cnt_d;
    logic [DUT_LAT-1:0]  vpipe;
    logic                launch;
    logic [MISR_W-1:0]   sig_next;

    // The pattern counter is reused to time DRAIN; it is cleared on each
    // phase entry so both phases count from zero.
    always_comb begin
        state_d = state;
        lfsr_d  = lfsr;
        cnt_d   = cnt;
        launch  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    launch  = 1'b1;
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                lfsr_d = lfsr_next(lfsr);
                if (cnt == PAT_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            DRAIN: begin
                if (cnt == LAT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so that dut_in
    // carries SEED in the first RUN cycle and busy/done switch with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            lfsr   <= SEED;
            cnt    <= '0;
            vpipe  <= '0;
            dut_in <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            state  <= state_d;
            lfsr   <= lfsr_d;
            cnt    <= cnt_d;
            dut_in <= (state_d == RUN) ? lfsr_d : '0;
            busy   <= (state_d == RUN) || (state_d == DRAIN);
            done   <= (state_d == DONE);

            if (launch) begin
                vpipe <= '0;
            end else begin
                vpipe[0] <= (state == RUN);
                for (int unsigned i = 1; i < DUT_LAT; i++) begin
                    vpipe[i] <= vpipe[i-1];
                end
            end

            // The final capture lands on the DRAIN->DONE edge, so compare
            // the post-capture value rather than the registered signature.
            if (launch) begin
                pass <= 1'b0;
            end else if ((state_d == DONE) && (state != DONE)) begin
                pass <= (sig_next == GOLDEN);
            end
        end
    end

    misr16 u_misr (
        .clk      (clk),
        .reset    (reset),
        .enable   (vpipe[DUT_LAT-1]),
        .clear    (launch),
        .data     (dut_out),
        .sig      (signature),
        .sig_next (sig_next)
    );

endmodule

// File: tb/tb_part4_bist.sv
// tb_part4_bist
//   Four part4_bist instances share clock, reset and start:
//     A: 5 patterns, latency 1, driven by a latency-1 stand-in for Part4
//     B: 2 patterns, latency 1, response tied 5'h1F, GOLDEN 16'h0021
//     C: as B with GOLDEN 16'h0000
//     D: 63 patterns, latency 3, seed 6'h2D, latency-3 stand-in for Part4
//   A run-timeline model predicts every output each cycle; a few literal
//   expectations pin the LFSR sequence and MISR arithmetic.
module tb_part4_bist;

    logic clk = 1'b0;
    logic reset;
    logic start;

    always #5 clk = ~clk;

    logic [5:0]  a_din, b_din, c_din, d_din;
    logic [4:0]  a_dout = '0;
    logic [4:0]  d_p0 = '0, d_p1 = '0, d_p2 = '0;
    logic        a_busy, b_busy, c_busy, d_busy;
    logic        a_done, b_done, c_done, d_done;
    logic        a_pass, b_pass, c_pass, d_pass;
    logic [15:0] a_sig, b_sig, c_sig, d_sig;

    int n_checks = 0;
    int n_err    = 0;

    // per-instance run parameters, in instance order A, B, C, D
    int pc  [4] = '{5, 2, 2, 63};
    int lat [4] = '{1, 1, 1, 3};
    int sd  [4] = '{1, 1, 1, 'h2D};
    int gold[4] = '{0, 'h21, 0, 0};
    int mode[4] = '{1, 0, 0, 1};   // 1: stand-in Part4, 0: constant 5'h1F

    int run_n[4] = '{-1, -1, -1, -1};
    int ecount   = 0;
    bit armed    = 1'b0;

    typedef struct packed {
        logic [5:0]  din;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] sig;
    } exp_t;

    function automatic logic [4:0] resp(input logic [5:0] x);
        return 5'((x * 6'd5) ^ (x >> 2) ^ 6'h0A);
    endfunction

    // Expected outputs t cycles into a run (t = 1 is the first stimulus cycle,
    // t = 0 means no run since reset).
    function automatic exp_t model(input int p, input int l, input int seed,
                                   input int g, input int m, input int t);
        exp_t e;
        int   q, s, n, d;
        e = '0;
        if (t < 1) return e;
        q = seed;
        s = 0;
        n = t - 1 - l;
        if (n < 0) n = 0;
        if (n > p) n = p;
        for (int j = 1; j <= p; j++) begin
            if (j == t) e.din = 6'(q);
            if (j <= n) begin
                d = (m == 1) ? int'(resp(6'(q))) : 'h1F;
                s = ((s << 1) & 'hFFFF) ^ (((s >> 15) & 1) != 0 ? 'h1021 : 0) ^ d;
            end
            q = ((q << 1) & 63) | (((q >> 5) ^ (q >> 4)) & 1);
        end
        e.busy = (t <= p + l);
        e.done = (t > p + l);
        e.sig  = 16'(s);
        e.pass = e.done && (s == g);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_inst(input string nm, input int k, input logic [5:0] din,
                              input logic busy, input logic done, input logic pass,
                              input logic [15:0] sig);
        int   t;
        exp_t e;
        t = (run_n[k] < 0) ? 0 : ecount + 1 - run_n[k];
        e = model(pc[k], lat[k], sd[k], gold[k], mode[k], t);
        chk($sformatf("%s.dut_in t=%0d", nm, t), 32'(din),  32'(e.din));
        chk($sformatf("%s.busy t=%0d",   nm, t), 32'(busy), 32'(e.busy));
        chk($sformatf("%s.done t=%0d",   nm, t), 32'(done), 32'(e.done));
        chk($sformatf("%s.pass t=%0d",   nm, t), 32'(pass), 32'(e.pass));
        chk($sformatf("%s.sig t=%0d",    nm, t), 32'(sig),  32'(e.sig));
    endtask

    part4_bist #(.PAT_COUNT(5), .SEED(6'h01), .DUT_LAT(1), .GOLDEN(16'h0000)) u_a (
        .clk(clk), .reset(reset), .start(start), .dut_in(a_din), .dut_out(a_dout),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig));

    part4_bist #(.PAT_COUNT(2), .SEED(6'h01), .DUT_LAT(1), .GOLDEN(16'h0021)) u_b (
        .clk(clk), .reset(reset), .start(start), .dut_in(b_din), .dut_out(5'h1F),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig));

    part4_bist #(.PAT_COUNT(2), .SEED(6'h01), .DUT_LAT(1), .GOLDEN(16'h0000)) u_c (
        .clk(clk), .reset(reset), .start(start), .dut_in(c_din), .dut_out(5'h1F),
        .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig));

    part4_bist #(.PAT_COUNT(63), .SEED(6'h2D), .DUT_LAT(3), .GOLDEN(16'h0000)) u_d (
        .clk(clk), .reset(reset), .start(start), .dut_in(d_din), .dut_out(d_p2),
        .busy(d_busy), .done(d_done), .pass(d_pass), .signature(d_sig));

    // Part4 stand-ins with the configured response latency
    always @(posedge clk) begin
        a_dout <= resp(a_din);
        d_p0   <= resp(d_din);
        d_p1   <= d_p0;
        d_p2   <= d_p1;
    end

    // Run tracking: which edge each instance accepted its latest start on
    always @(posedge clk) begin
        ecount = ecount + 1;
        for (int k = 0; k < 4; k++) begin
            if (!reset) begin
                run_n[k] = -1;
            end else if (start && (run_n[k] < 0 || ecount - run_n[k] > pc[k] + lat[k])) begin
                run_n[k] = ecount;
            end
        end
        if (!reset) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check_inst("A", 0, a_din, a_busy, a_done, a_pass, a_sig);
            check_inst("B", 1, b_din, b_busy, b_done, b_pass, b_sig);
            check_inst("C", 2, c_din, c_busy, c_done, c_pass, c_sig);
            check_inst("D", 3, d_din, d_busy, d_done, d_pass, d_sig);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [5:0] seq [6];
        int busy_cnt;
        int w;
        seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h00};

        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        chk("idle dut_in",    32'(a_din),  32'h0);
        chk("idle busy",      32'(a_busy), 32'h0);
        chk("idle done",      32'(a_done), 32'h0);
        chk("idle pass",      32'(a_pass), 32'h0);
        chk("idle signature", 32'(a_sig),  32'h0);

        // single start pulse; a second pulse lands while B/C are in DRAIN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 6) chk($sformatf("A pattern %0d", k), 32'(a_din), 32'(seq[k-1]));
            busy_cnt = busy_cnt + int'(a_busy);
            if (k == 3) begin
                chk("B sig first capture", 32'(b_sig), 32'h001F);
                start = 1'b1;
            end
            if (k == 4) begin
                start = 1'b0;
                chk("B sig final", 32'(b_sig),  32'h0021);
                chk("B done",      32'(b_done), 32'h1);
                chk("B pass",      32'(b_pass), 32'h1);
                chk("C done",      32'(c_done), 32'h1);
                chk("C pass",      32'(c_pass), 32'h0);
            end
            if (k == 6) begin
                chk("B done after drain start", 32'(b_done), 32'h1);
                chk("B sig held",               32'(b_sig),  32'h0021);
            end
            @(negedge clk);
        end
        chk("A busy cycles", 32'(busy_cnt), 32'd6);

        w = 0;
        while (!d_done && w < 100) begin
            @(negedge clk);
            w = w + 1;
        end
        chk("D done within budget", 32'(d_done), 32'h1);

        // start held high: instances restart straight out of DONE
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (75) @(negedge clk);

        // reset asserted during the third RUN cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset dut_in",    32'(a_din),  32'h0);
        chk("reset busy",      32'(a_busy), 32'h0);
        chk("reset done",      32'(a_done), 32'h0);
        chk("reset pass",      32'(a_pass), 32'h0);
        chk("reset signature", 32'(a_sig),  32'h0);
        chk("reset D busy",    32'(d_busy), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rerun dut_in seed",   32'(a_din), 32'h01);
        chk("rerun signature",     32'(a_sig), 32'h0);

        w = 0;
        while (!d_done && w < 100) begin
            @(negedge clk);
            w = w + 1;
        end
        chk("D rerun done within budget", 32'(d_done), 32'h1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
